key_debounce8: RTL and testbench

Eight-channel switch debouncer and key-select latch that sits directly upstream of the tube_display stage. It synchronises eight raw switch/button inputs, debounces each one independently, and emits one-cycle press and release pulses. It also holds a one-hot "last pressed key" word, `sel`, which drives the 8-bit `x` input of the priority-encoder/seven-segment stage.

---
 rtl/key_debounce8.sv | 92 +++++++++
 tb/tb_key_debounce8.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce8.sv
// Eight-channel key debouncer with press/release pulses and a one-hot
// "last pressed key" latch feeding the tube_display x input.
module key_debounce8 #(
  parameter int unsigned STABLE_CYCLES = 20000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_raw,
  input  logic       clear,
  output logic [7:0] key_level,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic [7:0] sel,
  output logic       sel_valid
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_level;
  logic [7:0]       r_press;
  logic [7:0]       r_release;
  logic [7:0]       r_sel;
  logic [CNT_W-1:0] r_cnt   [8];
  logic [CNT_W-1:0] w_cnt_d [8];
  logic [7:0]       w_accept;
  logic [7:0]       w_sel_hi;

  // A channel accepts only while s2 differs from its level, so an accept is a toggle.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < 8; i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (r_s2[i] == r_level[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntMax) begin
        w_cnt_d[i]  = '0;
        w_accept[i] = 1'b1;
      end else begin
        w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Highest pressed index wins; ascending loop lets later bits override.
  always_comb begin
    w_sel_hi = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_press[i]) begin
        w_sel_hi    = '0;
        w_sel_hi[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_sel     <= '0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= key_raw;
      r_s2      <= r_s1;
      r_level   <= r_level ^ w_accept;
      r_press   <= w_accept & r_s2;
      r_release <= w_accept & ~r_s2;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
      if (clear) begin
        r_sel <= '0;
      end else if (|r_press) begin
        r_sel <= w_sel_hi;
      end
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign sel         = r_sel;
  assign sel_valid   = |r_sel;

endmodule

// File: tb/tb_key_debounce8.sv
// Directed bench for key_debounce8 with STABLE_CYCLES = 4; expectations are
// queued as each step is driven and compared against the DUT when drained.
module tb_key_debounce8;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_raw;
  logic       clear;
  logic [7:0] key_level;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic [7:0] sel;
  logic       sel_valid;

  int checks = 0;
  int errors = 0;

  typedef enum int {KLevel, KPress, KRelease, KSel, KValid} kind_e;
  typedef struct {
    string      tag;
    kind_e      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];

  key_debounce8 #(
    .STABLE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .clear      (clear),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sel        (sel),
    .sel_valid  (sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input kind_e k, input logic [7:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [7:0] observe(input kind_e k);
    case (k)
      KLevel:   return key_level;
      KPress:   return key_press;
      KRelease: return key_release;
      KSel:     return sel;
      default:  return {7'b0, sel_valid};
    endcase
  endfunction

  task automatic drain();
    exp_t       e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Wait n rising edges and settle just after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    push({tag, "_level"}, KLevel, 8'h00);
    push({tag, "_press"}, KPress, 8'h00);
    push({tag, "_rel"}, KRelease, 8'h00);
    push({tag, "_sel"}, KSel, 8'h00);
    push({tag, "_valid"}, KValid, 8'h00);
    drain();
  endtask

  logic bounce [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset with all keys asserted: outputs must still be zero
    rst_n   = 1'b0;
    clear   = 1'b0;
    key_raw = 8'hFF;
    #12;
    all_zero("rst");
    key_raw = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges(2);
    all_zero("post_rst");

    // Clean press on bit 2
    key_raw = 8'h04;
    edges(5);
    push("clean_early_level", KLevel, 8'h00);
    push("clean_early_press", KPress, 8'h00);
    drain();
    edges(1);
    push("clean_level", KLevel, 8'h04);
    push("clean_press", KPress, 8'h04);
    push("clean_sel_before", KSel, 8'h00);
    drain();
    edges(1);
    push("clean_press_gone", KPress, 8'h00);
    push("clean_sel", KSel, 8'h04);
    push("clean_valid", KValid, 8'h01);
    drain();

    // Bounce on bit 1 while bit 2 stays held
    for (int i = 0; i < 7; i++) begin
      key_raw = {6'b0, 1'b1, bounce[i]} << 1;
      edges(1);
      push("bounce_no_press", KPress, 8'h00);
      drain();
    end
    key_raw = 8'h06;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      push("steady_wait_press", KPress, 8'h00);
      drain();
    end
    edges(1);
    push("bounce_press", KPress, 8'h02);
    push("bounce_level", KLevel, 8'h06);
    drain();
    edges(1);
    push("bounce_single_pulse", KPress, 8'h00);
    push("bounce_sel", KSel, 8'h02);
    drain();

    // Release everything; sel must survive releases
    key_raw = 8'h00;
    edges(6);
    push("relall_rel", KRelease, 8'h06);
    push("relall_level", KLevel, 8'h00);
    drain();
    edges(1);
    push("relall_rel_gone", KRelease, 8'h00);
    push("relall_sel_kept", KSel, 8'h02);
    drain();

    // Simultaneous press of bits 7 and 0
    key_raw = 8'h81;
    edges(6);
    push("simul_press", KPress, 8'h81);
    drain();
    edges(1);
    push("simul_sel", KSel, 8'h80);
    push("simul_press_gone", KPress, 8'h00);
    drain();
    key_raw = 8'h01;
    edges(6);
    push("simul_rel7", KRelease, 8'h80);
    push("simul_rel7_press", KPress, 8'h00);
    push("simul_rel7_level", KLevel, 8'h01);
    drain();
    edges(1);
    push("simul_rel7_sel", KSel, 8'h80);
    drain();
    key_raw = 8'h00;
    edges(7);
    push("simul_rel0_level", KLevel, 8'h00);
    drain();
    key_raw = 8'h01;
    edges(6);
    push("simul_repress0", KPress, 8'h01);
    drain();
    edges(1);
    push("simul_sel0", KSel, 8'h01);
    push("simul_valid0", KValid, 8'h01);
    drain();

    // Clear in the same cycle as a press of bit 4
    key_raw = 8'h10;
    edges(6);
    push("clr_press", KPress, 8'h10);
    push("clr_sel_before", KSel, 8'h01);
    drain();
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    push("clr_vs_press_sel", KSel, 8'h00);
    push("clr_vs_press_valid", KValid, 8'h00);
    drain();
    edges(2);
    push("clr_hold_sel", KSel, 8'h00);
    drain();
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    push("clr_alone_sel", KSel, 8'h00);
    push("clr_alone_valid", KValid, 8'h00);
    drain();

    // Clear of a non-zero selection
    key_raw = 8'h50;
    edges(6);
    push("clr2_press", KPress, 8'h40);
    drain();
    edges(1);
    push("clr2_sel", KSel, 8'h40);
    drain();
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    push("clr2_cleared", KSel, 8'h00);
    drain();

    // Press bit 5 (releasing 4 and 6), then release path on bit 5
    key_raw = 8'h20;
    edges(6);
    push("b5_press", KPress, 8'h20);
    push("b5_rel46", KRelease, 8'h50);
    push("b5_level", KLevel, 8'h20);
    drain();
    edges(1);
    push("b5_sel", KSel, 8'h20);
    drain();
    key_raw = 8'h00;
    edges(5);
    push("relp_early", KRelease, 8'h00);
    push("relp_early_level", KLevel, 8'h20);
    drain();
    edges(1);
    push("relp_rel", KRelease, 8'h20);
    push("relp_level", KLevel, 8'h00);
    push("relp_sel", KSel, 8'h20);
    drain();
    edges(1);
    push("relp_rel_gone", KRelease, 8'h00);
    push("relp_sel_kept", KSel, 8'h20);
    drain();

    // Reset while bit 3 is two counts into debounce
    key_raw = 8'h08;
    edges(4);
    rst_n = 1'b0;
    #2;
    all_zero("midrst");
    edges(2);
    rst_n = 1'b1;
    edges(5);
    push("midrst_wait_press", KPress, 8'h00);
    push("midrst_wait_level", KLevel, 8'h00);
    drain();
    edges(1);
    push("midrst_press", KPress, 8'h08);
    push("midrst_level", KLevel, 8'h08);
    drain();
    edges(1);
    push("midrst_sel", KSel, 8'h08);
    push("midrst_press_gone", KPress, 8'h00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
